// File: rtl/int_execute_stage.sv
// Integer execute stage: single-cycle ALU ops plus a 32-step restoring divider
// under a small IDLE/BUSY/DONE controller, feeding a stallable output register.
module int_execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        memStall,
  input  logic        inValid,
  input  logic [31:0] inPc,
  input  logic [3:0]  inOp,
  input  logic [31:0] inSrc1,
  input  logic [31:0] inSrc2,
  input  logic [31:0] inImm,
  input  logic        inUseImm,
  input  logic [4:0]  inRd,
  input  logic        inRegWrite,
  output logic        exStall,
  output logic        outValid,
  output logic [31:0] outPc,
  output logic [4:0]  outRd,
  output logic        outRegWrite,
  output logic [31:0] outResult
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvsr;
  logic        neg_q;
  logic        neg_r;
  logic        want_rem;

  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sra;
    logic [63:0]        prod;
    sa   = a;
    sb   = b;
    sra  = sa >>> b[4:0];
    prod = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:    alu = a + b;
      4'd1:    alu = a - b;
      4'd2:    alu = a << b[4:0];
      4'd3:    alu = {31'd0, sa < sb};
      4'd4:    alu = {31'd0, a < b};
      4'd5:    alu = a ^ b;
      4'd6:    alu = a >> b[4:0];
      4'd7:    alu = sra;
      4'd8:    alu = a | b;
      4'd9:    alu = a & b;
      4'd10:   alu = prod[31:0];
      default: alu = 32'd0;
    endcase
  endfunction

  // One restoring step: returns {next remainder, next quotient/dividend shift}.
  function automatic logic [63:0] div_step(input logic [31:0] r, input logic [31:0] q,
                                           input logic [31:0] d);
    logic [32:0] t;
    t = {r, q[31]};
    if (t >= {1'b0, d}) begin
      t = t - {1'b0, d};
      div_step = {t[31:0], q[30:0], 1'b1};
    end else begin
      div_step = {t[31:0], q[30:0], 1'b0};
    end
  endfunction

  function automatic logic [31:0] sign_fix(input logic [31:0] v, input logic neg);
    sign_fix = neg ? (32'd0 - v) : v;
  endfunction

  logic [31:0] op_b;
  logic        is_div;
  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        div_zero;
  logic        div_ovf;
  logic        div_start;
  logic        div_pending;
  logic [63:0] step_nxt;
  logic [31:0] div_res;

  always_comb begin
    op_b        = inUseImm ? inImm : inSrc2;
    is_div      = (inOp >= 4'd11) && (inOp <= 4'd14);
    div_signed  = (inOp == 4'd11) || (inOp == 4'd13);
    a_neg       = div_signed & inSrc1[31];
    b_neg       = div_signed & op_b[31];
    mag_a       = a_neg ? (32'd0 - inSrc1) : inSrc1;
    mag_b       = b_neg ? (32'd0 - op_b) : op_b;
    div_zero    = (op_b == 32'd0);
    div_ovf     = div_signed && (inSrc1 == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    div_start   = (state == IDLE) && inValid && is_div && !flush && !memStall;
    div_pending = (state == BUSY) || ((state == IDLE) && inValid && is_div);
    step_nxt    = div_step(rem, quo, dvsr);
    div_res     = want_rem ? sign_fix(rem, neg_r) : sign_fix(quo, neg_q);
    exStall     = memStall | (!rst && div_pending);
  end

  // Divider controller and datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      quo      <= 32'd0;
      rem      <= 32'd0;
      dvsr     <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      want_rem <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= 6'd0;
      quo   <= 32'd0;
      rem   <= 32'd0;
    end else begin
      case (state)
        IDLE: if (div_start) begin
          want_rem <= (inOp == 4'd13) || (inOp == 4'd14);
          cnt      <= 6'd0;
          if (div_zero) begin
            quo   <= 32'hFFFF_FFFF;
            rem   <= inSrc1;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            state <= DONE;
          end else if (div_ovf) begin
            quo   <= 32'h8000_0000;
            rem   <= 32'd0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            state <= DONE;
          end else begin
            quo   <= mag_a;
            rem   <= 32'd0;
            dvsr  <= mag_b;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            state <= BUSY;
          end
        end
        BUSY: begin
          rem <= step_nxt[63:32];
          quo <= step_nxt[31:0];
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= DONE;
        end
        DONE: if (!memStall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output register to the memory stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      outValid    <= 1'b0;
      outPc       <= 32'd0;
      outRd       <= 5'd0;
      outRegWrite <= 1'b0;
      outResult   <= 32'd0;
    end else if (!memStall) begin
      if (state == DONE) begin
        outValid    <= 1'b1;
        outPc       <= inPc;
        outRd       <= inRd;
        outRegWrite <= inRegWrite;
        outResult   <= div_res;
      end else if (div_pending || !inValid) begin
        outValid    <= 1'b0;
        outPc       <= 32'd0;
        outRd       <= 5'd0;
        outRegWrite <= 1'b0;
        outResult   <= 32'd0;
      end else begin
        outValid    <= 1'b1;
        outPc       <= inPc;
        outRd       <= inRd;
        outRegWrite <= inRegWrite;
        outResult   <= alu(inOp, inSrc1, op_b);
      end
    end
  end

endmodule

// File: tb/tb_int_execute_stage.sv
// Directed bench for int_execute_stage: ALU ops, divider latency and special
// cases, flush, memStall hold and reset abort, checked with immediate assertions.
module tb_int_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        memStall;
  logic        inValid;
  logic [31:0] inPc;
  logic [3:0]  inOp;
  logic [31:0] inSrc1;
  logic [31:0] inSrc2;
  logic [31:0] inImm;
  logic        inUseImm;
  logic [4:0]  inRd;
  logic        inRegWrite;
  logic        exStall;
  logic        outValid;
  logic [31:0] outPc;
  logic [4:0]  outRd;
  logic        outRegWrite;
  logic [31:0] outResult;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  int_execute_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .memStall(memStall),
    .inValid(inValid), .inPc(inPc), .inOp(inOp), .inSrc1(inSrc1), .inSrc2(inSrc2),
    .inImm(inImm), .inUseImm(inUseImm), .inRd(inRd), .inRegWrite(inRegWrite),
    .exStall(exStall), .outValid(outValid), .outPc(outPc), .outRd(outRd),
    .outRegWrite(outRegWrite), .outResult(outResult)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] pc);
    inValid    = v;
    inOp       = op;
    inSrc1     = a;
    inSrc2     = b;
    inImm      = 32'd0;
    inUseImm   = 1'b0;
    inRd       = rd;
    inPc       = pc;
    inRegWrite = 1'b1;
  endtask

  task automatic alu_case(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    drive(1'b1, op, a, b, 5'd9, 32'h40);
    cyc();
    chk({tag, "_res"}, outResult, exp);
    chk({tag, "_vld"}, 32'(outValid), 32'd1);
  endtask

  task automatic run_div(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    drive(1'b1, op, a, b, 5'd7, 32'h200);
    #1;
    chk({tag, "_stall_T"}, 32'(exStall), 32'd1);
    for (int k = 1; k <= 32; k++) begin
      cyc();
      chk({tag, "_stall_busy"}, 32'(exStall), 32'd1);
    end
    cyc();
    chk({tag, "_stall_done"}, 32'(exStall), 32'd0);
    chk({tag, "_bubble"}, 32'(outValid), 32'd0);
    cyc();
    chk({tag, "_vld"}, 32'(outValid), 32'd1);
    chk({tag, "_res"}, outResult, exp);
    chk({tag, "_rd"}, 32'(outRd), 32'd7);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 32'd0);
  endtask

  task automatic run_special(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
    drive(1'b1, op, a, b, 5'd4, 32'h300);
    #1;
    chk({tag, "_stall_T"}, 32'(exStall), 32'd1);
    cyc();
    chk({tag, "_stall_T1"}, 32'(exStall), 32'd0);
    chk({tag, "_bubble"}, 32'(outValid), 32'd0);
    cyc();
    chk({tag, "_vld"}, 32'(outValid), 32'd1);
    chk({tag, "_res"}, outResult, exp);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; memStall = 1'b0;
    drive(1'b1, 4'd11, 32'd100, 32'd3, 5'd1, 32'h10);
    #3;
    chk("rst_stall", 32'(exStall), 32'd0);
    chk("rst_vld", 32'(outValid), 32'd0);
    chk("rst_res", outResult, 32'd0);
    memStall = 1'b1;
    #1;
    chk("rst_memstall", 32'(exStall), 32'd1);
    memStall = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 32'd0);
    cyc();

    drive(1'b1, 4'd0, 32'd5, 32'd7, 5'd3, 32'h100);
    cyc();
    chk("add_vld", 32'(outValid), 32'd1);
    chk("add_res", outResult, 32'd12);
    chk("add_rd", 32'(outRd), 32'd3);
    chk("add_pc", outPc, 32'h100);
    chk("add_we", 32'(outRegWrite), 32'd1);

    alu_case("sub",  4'd1,  32'd3,         32'd5,         32'hFFFF_FFFE);
    alu_case("sll",  4'd2,  32'd1,         32'h21,        32'd2);
    alu_case("slt",  4'd3,  32'hFFFF_FFFF, 32'd1,         32'd1);
    alu_case("sltu", 4'd4,  32'hFFFF_FFFF, 32'd1,         32'd0);
    alu_case("xor",  4'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    alu_case("srl",  4'd6,  32'h8000_0000, 32'd4,         32'h0800_0000);
    alu_case("sra",  4'd7,  32'h8000_0000, 32'd4,         32'hF800_0000);
    alu_case("or",   4'd8,  32'hF0F0_0000, 32'h0000_F0F0, 32'hF0F0_F0F0);
    alu_case("and",  4'd9,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    alu_case("mul",  4'd10, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000);
    alu_case("mul2", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    alu_case("op15", 4'd15, 32'd5,         32'd7,         32'd0);

    drive(1'b1, 4'd1, 32'd10, 32'd99, 5'd2, 32'h44);
    inImm = 32'd3;
    inUseImm = 1'b1;
    cyc();
    chk("imm_res", outResult, 32'd7);

    drive(1'b0, 4'd0, 32'd1, 32'd1, 5'd2, 32'h48);
    cyc();
    chk("inv_vld", 32'(outValid), 32'd0);
    chk("inv_we", 32'(outRegWrite), 32'd0);

    run_div("div_m7_2", 4'd11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_div("rem_m7_2", 4'd13, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_div("divu",     4'd12, 32'd100,       32'd7, 32'd14);
    run_div("remu",     4'd14, 32'hFFFF_FFFF, 32'h10, 32'hF);

    run_special("divu_z",  4'd12, 32'd9,         32'd0,         32'hFFFF_FFFF);
    run_special("remu_z",  4'd14, 32'd9,         32'd0,         32'd9);
    run_special("rem_z",   4'd13, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9);
    run_special("div_ovf", 4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_special("rem_ovf", 4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    drive(1'b1, 4'd11, 32'd100, 32'd3, 5'd8, 32'h500);
    for (int k = 0; k < 10; k++) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 32'd0);
    #1;
    chk("flush_stall", 32'(exStall), 32'd0);
    chk("flush_vld", 32'(outValid), 32'd0);
    drive(1'b1, 4'd0, 32'd1, 32'd2, 5'd6, 32'h504);
    cyc();
    chk("flush_add_res", outResult, 32'd3);
    chk("flush_add_vld", 32'(outValid), 32'd1);

    drive(1'b1, 4'd11, 32'd100, 32'd3, 5'd8, 32'h600);
    for (int k = 0; k < 32; k++) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 32'd0);
    #1;
    chk("flush_done_stall", 32'(exStall), 32'd0);
    cyc();
    chk("flush_done_vld", 32'(outValid), 32'd0);

    drive(1'b1, 4'd0, 32'd20, 32'd22, 5'd5, 32'h700);
    cyc();
    chk("hold_pre", outResult, 32'd42);
    drive(1'b1, 4'd1, 32'd50, 32'd9, 5'd6, 32'h704);
    memStall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_stall", 32'(exStall), 32'd1);
      cyc();
      chk("hold_res", outResult, 32'd42);
      chk("hold_rd", 32'(outRd), 32'd5);
    end
    memStall = 1'b0;
    cyc();
    chk("hold_post_res", outResult, 32'd41);
    chk("hold_post_rd", 32'(outRd), 32'd6);

    drive(1'b1, 4'd12, 32'd100, 32'd7, 5'd10, 32'h800);
    for (int k = 0; k < 33; k++) cyc();
    memStall = 1'b1;
    #1;
    chk("done_ms_stall", 32'(exStall), 32'd1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("done_ms_stall_n", 32'(exStall), 32'd1);
      chk("done_ms_vld", 32'(outValid), 32'd0);
    end
    memStall = 1'b0;
    #1;
    chk("done_ms_release", 32'(exStall), 32'd0);
    cyc();
    chk("done_ms_vld_out", 32'(outValid), 32'd1);
    chk("done_ms_res", outResult, 32'd14);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 32'd0);
    cyc();

    drive(1'b1, 4'd11, 32'd100, 32'd3, 5'd8, 32'h900);
    for (int k = 0; k < 5; k++) cyc();
    rst = 1'b1;
    #1;
    chk("rst_mid_stall", 32'(exStall), 32'd0);
    chk("rst_mid_vld", 32'(outValid), 32'd0);
    cyc();
    rst = 1'b0;
    drive(1'b1, 4'd0, 32'd3, 32'd4, 5'd12, 32'h904);
    cyc();
    chk("rst_after_res", outResult, 32'd7);
    chk("rst_after_vld", 32'(outValid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/int_execute_stage.md
INT_EXECUTE_STAGE -- requirements
Module: int_execute_stage

Interface
REQ-001 Parameters: none; data width is fixed at 32 bits.
REQ-002 Clock and reset SHALL be: one clock; reset is asynchronous and active-high (ports clk, rst).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  kill in-flight op and clear the output register.
REQ-006 memStall  input  1  downstream stall; hold the output register.
REQ-007 inValid  input  1  an op is present from the register-read stage.
REQ-008 inPc  input  32  pc of the op.
REQ-009 inOp  input  4  ALU op code: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL, 11 DIV, 12 DIVU, 13 REM, 14 REMU, 15 reserved.
REQ-010 inSrc1 / inSrc2  input  32 each  register operand values.
REQ-011 inImm  input  32  immediate.
REQ-012 inUseImm  input  1  when 1, operand B = inImm; otherwise operand B = inSrc2.
REQ-013 inRd  input  5  destination register.
REQ-014 inRegWrite  input  1  op writes rd.
REQ-015 exStall  output  1  hold upstream stages (register-read and earlier).
REQ-016 outValid, outPc, outRd, outRegWrite, outResult  output  1/32/5/1/32  registered result to the memory stage.

Function
REQ-017 Single-cycle ops (0-10, 15) SHALL be registered at the end of the presenting cycle T and be visible at T+1.
- Shift amount is B[4:0].
- MUL returns the low 32 bits of the product.
- Op 15 returns 0.
REQ-018 Divide ops (11-14) SHALL use an FSM with states IDLE, BUSY and DONE, and a 6-bit iteration counter.
REQ-019 IDLE with inValid and a divide op, no flush, no memStall:
- normal case: latch operand magnitudes and result signs, counter=0, go to BUSY;
- divisor==0 or signed overflow (0x80000000 / -1): go directly to DONE.
REQ-020 BUSY SHALL perform one restoring-division step per cycle and go to DONE after 32 steps, independent of memStall.
REQ-021 DONE SHALL apply the sign fix-up and load the output register at the cycle end, then go to IDLE; if memStall is 1, stay in DONE.
REQ-022 exStall SHALL equal memStall OR (IDLE and valid divide op) OR BUSY; in DONE, exStall SHALL equal memStall.
REQ-023 Special results:
- divide by zero: quotient 0xFFFFFFFF, remainder = dividend;
- signed overflow: quotient 0x80000000, remainder 0.
REQ-024 Signed results: quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
REQ-025 Normal divide latency: presented at T, exStall high T..T+32, DONE at T+33, output visible at T+34. Special cases: output visible at T+2.
REQ-026 Output register update priority (high to low):
- rst: clear;
- flush: clear;
- memStall: hold;
- divide not yet in DONE: load a bubble (outValid=0);
- otherwise: load the op.
REQ-027 flush SHALL return the FSM to IDLE and discard partial quotient/remainder, including when flush coincides with entry to DONE.
REQ-028 inValid=0 SHALL never start a divide; it SHALL load a bubble (outValid=0, outRegWrite=0).
REQ-029 outRegWrite SHALL be forced to 0 whenever outValid is 0.

Reset
REQ-030 While rst is high, all outputs and state SHALL be 0 and the FSM SHALL be IDLE; exStall SHALL be 0 unless memStall is 1.
REQ-031 rst asserted mid-divide SHALL abort it immediately; the first op after reset release SHALL be processed normally.

Verification
REQ-032 ADD 5+7, rd=3 at T -> at T+1: outValid=1, outResult=12, outRd=3.
REQ-033 DIV inSrc1=0xFFFFFFF9 (-7), inSrc2=2 -> exStall=1 over T..T+32; at T+34: outResult=0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF.
REQ-034 DIVU 9/0 -> outResult=0xFFFFFFFF at T+2. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
REQ-035 flush at the 10th BUSY cycle -> next cycle: FSM IDLE, outValid=0, exStall=0; a following ADD completes at +1.
REQ-036 memStall=1 for 3 cycles while a result sits in the output register -> outputs unchanged; exStall=1 throughout. A divide reaching DONE under memStall stays in DONE until memStall falls.
